// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter sharing one slave port.
// A grant lasts for a whole bus cycle (CYC high); the block only steers
// control/data and never buffers them.
// Optional build macro: WB_ARB_WATCHDOG_EN adds a stalled-slave watchdog
// that aborts the cycle with a one-cycle ERR to the owning master.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grant; slave CYC/STB low, data path parked on last_gnt
// GNT0  | master 0 owns the slave port for its whole CYC
// GNT1  | master 1 owns the slave port for its whole CYC
// TERM  | watchdog abort: slave CYC/STB forced low, ERR on first cycle
module wb_arbiter_2m #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [AWIDTH-1:0]   m0_adr_i,
  input  logic [DWIDTH-1:0]   m0_dat_i,
  output logic [DWIDTH-1:0]   m0_dat_o,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [DWIDTH/8-1:0] m0_sel_i,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  output logic                m0_rty_o,
  input  logic [AWIDTH-1:0]   m1_adr_i,
  input  logic [DWIDTH-1:0]   m1_dat_i,
  output logic [DWIDTH-1:0]   m1_dat_o,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [DWIDTH/8-1:0] m1_sel_i,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic                m1_rty_o,
  output logic [AWIDTH-1:0]   s_adr_o,
  output logic [DWIDTH-1:0]   s_dat_o,
  input  logic [DWIDTH-1:0]   s_dat_i,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [DWIDTH/8-1:0] s_sel_o,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  input  logic                s_rty_i,
  output logic [1:0]          gnt_o
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_arbiter_2m: TIMEOUT must be within 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
`ifdef WB_ARB_WATCHDOG_EN
    , ST_TERM = 2'd3
`endif
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic       last_gnt_q;
  logic [1:0] gnt_q;
  logic       granted;
  logic       own_cyc;
  logic       other_cyc;
  logic       wd_hit;
  logic       term_err;
  logic       any_term;

  // last_gnt always names the current owner while granted, so it doubles
  // as the data-path select in every state.
  assign granted   = (state_q == ST_GNT0) || (state_q == ST_GNT1);
  assign own_cyc   = last_gnt_q ? m1_cyc_i : m0_cyc_i;
  assign other_cyc = last_gnt_q ? m0_cyc_i : m1_cyc_i;
  assign any_term  = s_ack_i | s_err_i | s_rty_i;

`ifdef WB_ARB_WATCHDOG_EN
  logic [15:0] wd_cnt_q;
  logic        term_first_q;

  // A termination arriving on the limit cycle still wins over the abort.
  assign wd_hit   = (wd_cnt_q == 16'(TIMEOUT)) && !any_term;
  assign term_err = term_first_q;

  // Watchdog: count unterminated strobe cycles, restart on grant change.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      wd_cnt_q     <= '0;
      term_first_q <= 1'b0;
    end else begin
      term_first_q <= (state_d == ST_TERM) && (state_q != ST_TERM);
      if ((state_d != state_q) || any_term)
        wd_cnt_q <= '0;
      else if (s_stb_o)
        wd_cnt_q <= wd_cnt_q + 16'd1;
    end
  end
`else
  assign wd_hit   = 1'b0;
  assign term_err = 1'b0;
`endif

  // Next-state: round-robin on ties, hand over directly on release.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i)
          state_d = last_gnt_q ? ST_GNT0 : ST_GNT1;
        else if (m0_cyc_i)
          state_d = ST_GNT0;
        else if (m1_cyc_i)
          state_d = ST_GNT1;
      end
      ST_GNT0: begin
        if (!m0_cyc_i)
          state_d = m1_cyc_i ? ST_GNT1 : ST_IDLE;
`ifdef WB_ARB_WATCHDOG_EN
        else if (wd_hit)
          state_d = ST_TERM;
`endif
      end
      ST_GNT1: begin
        if (!m1_cyc_i)
          state_d = m0_cyc_i ? ST_GNT0 : ST_IDLE;
`ifdef WB_ARB_WATCHDOG_EN
        else if (wd_hit)
          state_d = ST_TERM;
`endif
      end
`ifdef WB_ARB_WATCHDOG_EN
      ST_TERM: begin
        if (!own_cyc) begin
          if (other_cyc)
            state_d = last_gnt_q ? ST_GNT0 : ST_GNT1;
          else
            state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State, last-granted master and registered one-hot grant.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b1;
      gnt_q      <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_d == ST_GNT0)
        last_gnt_q <= 1'b0;
      else if (state_d == ST_GNT1)
        last_gnt_q <= 1'b1;
      case (state_d)
        ST_IDLE: gnt_q <= 2'b00;
        ST_GNT0: gnt_q <= 2'b01;
        ST_GNT1: gnt_q <= 2'b10;
        default: gnt_q <= gnt_q;
      endcase
    end
  end

  assign gnt_o    = gnt_q;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Slave-side mux and grant-gated termination routing.
  always_comb begin
    s_adr_o  = last_gnt_q ? m1_adr_i : m0_adr_i;
    s_dat_o  = last_gnt_q ? m1_dat_i : m0_dat_i;
    s_sel_o  = last_gnt_q ? m1_sel_i : m0_sel_i;
    s_we_o   = last_gnt_q ? m1_we_i  : m0_we_i;
    s_cyc_o  = granted & own_cyc;
    s_stb_o  = granted & (last_gnt_q ? m1_stb_i : m0_stb_i);
    m0_ack_o = granted & ~last_gnt_q & s_ack_i;
    m0_rty_o = granted & ~last_gnt_q & s_rty_i;
    m0_err_o = (granted & ~last_gnt_q & s_err_i) | (term_err & ~last_gnt_q);
    m1_ack_o = granted & last_gnt_q & s_ack_i;
    m1_rty_o = granted & last_gnt_q & s_rty_i;
    m1_err_o = (granted & last_gnt_q & s_err_i) | (term_err & last_gnt_q);
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: vector table, directed corner
// sequences (burst, mid-transfer reset, watchdog) and a randomized run
// against a behavioural ownership model.
module tb_wb_arbiter_2m;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_rty_i;
  logic [1:0]  gnt_o;

  int errors = 0;
  int checks = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_arbiter_2m #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m0_rty_o(m0_rty_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .s_rty_i(s_rty_i), .gnt_o(gnt_o)
  );

  typedef struct {
    logic       c0, c1, s0, s1, ack;
    logic [1:0] gnt;
    logic       cyc, stb, a0, a1;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    m0_adr_i = 32'h6000_0004; m0_dat_i = 32'hA5A5_1234; m0_sel_i = 4'hF;
    m1_adr_i = 32'h1000_0008; m1_dat_i = 32'h5A5A_0000; m1_sel_i = 4'h3;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    s_dat_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
  endtask

  task automatic do_reset();
    wb_rst_i = 0;
    repeat (3) tick();
    wb_rst_i = 1;
    tick();
  endtask

  // behavioural model state for the random phase
  int  owner;
  int  last;
  bit  c[2];
  logic [31:0] adr[2];
  int  stall;
  bit  ack;
  bit  stb_exp;
  logic [1:0] gnt_exp;

  initial begin
    tbl[0]  = '{1,1,1,1,0, 2'b01, 1,1,0,0};
    tbl[1]  = '{1,1,1,1,1, 2'b01, 1,1,1,0};
    tbl[2]  = '{0,1,0,1,0, 2'b10, 1,1,0,0};
    tbl[3]  = '{1,1,1,1,1, 2'b10, 1,1,0,1};
    tbl[4]  = '{1,0,1,0,0, 2'b01, 1,1,0,0};
    tbl[5]  = '{1,0,0,0,0, 2'b01, 1,0,0,0};
    tbl[6]  = '{0,0,0,0,0, 2'b00, 0,0,0,0};
    tbl[7]  = '{0,1,0,1,1, 2'b10, 1,1,0,1};
    tbl[8]  = '{0,0,0,0,1, 2'b00, 0,0,0,0};
    tbl[9]  = '{1,1,1,1,0, 2'b01, 1,1,0,0};
    tbl[10] = '{0,0,0,0,0, 2'b00, 0,0,0,0};

    idle_inputs();

    // reset held with a request and a stray ack present
    wb_rst_i = 0; m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1;
    repeat (3) tick();
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_cyc", 32'(s_cyc_o), 32'h0);
    chk("rst_stb", 32'(s_stb_o), 32'h0);
    chk("rst_ack", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'h0);
    idle_inputs();
    wb_rst_i = 1;
    tick();
    chk("rst_idle_gnt", 32'(gnt_o), 32'h0);

    // vector table: inputs applied, one edge, outputs checked
    for (int i = 0; i < 11; i++) begin
      m0_cyc_i = tbl[i].c0; m1_cyc_i = tbl[i].c1;
      m0_stb_i = tbl[i].s0; m1_stb_i = tbl[i].s1;
      s_ack_i  = tbl[i].ack;
      tick();
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt_o), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_cyc", i), 32'(s_cyc_o), 32'(tbl[i].cyc));
      chk($sformatf("tbl%0d_stb", i), 32'(s_stb_o), 32'(tbl[i].stb));
      chk($sformatf("tbl%0d_ack0", i), 32'(m0_ack_o), 32'(tbl[i].a0));
      chk($sformatf("tbl%0d_ack1", i), 32'(m1_ack_o), 32'(tbl[i].a1));
    end
    idle_inputs();

    // m0 single write: latency and routing
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1;
    #1;
    chk("wr_cyc_early", 32'(s_cyc_o), 32'h0);
    tick();
    chk("wr_cyc", 32'(s_cyc_o), 32'h1);
    chk("wr_gnt", 32'(gnt_o), 32'h1);
    chk("wr_adr", s_adr_o, 32'h6000_0004);
    chk("wr_dat", s_dat_o, 32'hA5A5_1234);
    chk("wr_sel", 32'(s_sel_o), 32'hF);
    chk("wr_we", 32'(s_we_o), 32'h1);
    tick();
    s_ack_i = 1;
    #1;
    chk("wr_ack0", 32'(m0_ack_o), 32'h1);
    chk("wr_ack1", 32'(m1_ack_o), 32'h0);
    tick();
    idle_inputs();
    tick();
    chk("wr_done_gnt", 32'(gnt_o), 32'h0);

    // m1 burst read while m0 waits (last_gnt = 0, so m1 wins the tie)
    m0_cyc_i = 1; m0_stb_i = 1;
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0;
    tick();
    chk("bur_gnt0", 32'(gnt_o), 32'h2);
    s_dat_i = 32'h0000_BEEF;
    for (int b = 0; b < 3; b++) begin
      m1_stb_i = 1; s_ack_i = 1;
      #1;
      chk($sformatf("bur%0d_ack1", b), 32'(m1_ack_o), 32'h1);
      chk($sformatf("bur%0d_ack0", b), 32'(m0_ack_o), 32'h0);
      chk($sformatf("bur%0d_dat", b), m1_dat_o, 32'h0000_BEEF);
      chk($sformatf("bur%0d_adr", b), s_adr_o, 32'h1000_0008);
      tick();
      m1_stb_i = 0; s_ack_i = 0;
      #1;
      chk($sformatf("bur%0d_stb_low", b), 32'(s_stb_o), 32'h0);
      chk($sformatf("bur%0d_cyc_hold", b), 32'(s_cyc_o), 32'h1);
      tick();
      chk($sformatf("bur%0d_gnt", b), 32'(gnt_o), 32'h2);
    end
    m1_cyc_i = 0;
    tick();
    chk("bur_handover", 32'(gnt_o), 32'h1);
    m0_cyc_i = 0; m0_stb_i = 0;
    tick();
    chk("bur_idle", 32'(gnt_o), 32'h0);

    // reset in the middle of a granted cycle
    m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    chk("mid_gnt", 32'(gnt_o), 32'h2);
    wb_rst_i = 0; s_ack_i = 1;
    tick();
    chk("mid_cyc", 32'(s_cyc_o), 32'h0);
    chk("mid_ack1", 32'(m1_ack_o), 32'h0);
    chk("mid_gnt_rst", 32'(gnt_o), 32'h0);
    idle_inputs();
    wb_rst_i = 1;
    tick();

    // hung slave
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    chk("hang_stb", 32'(s_stb_o), 32'h1);
`ifdef WB_ARB_WATCHDOG_EN
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("wd%0d_err", i), 32'(m0_err_o), (i == 9) ? 32'h1 : 32'h0);
      chk($sformatf("wd%0d_cyc", i), 32'(s_cyc_o), (i == 9) ? 32'h0 : 32'h1);
    end
    s_ack_i = 1;
    tick();
    chk("wd_err_once", 32'(m0_err_o), 32'h0);
    chk("wd_late_ack", 32'(m0_ack_o), 32'h0);
    chk("wd_cyc_low", 32'(s_cyc_o), 32'h0);
    idle_inputs();
    tick();
    chk("wd_release", 32'(gnt_o), 32'h0);
`else
    repeat (100) tick();
    chk("hang_cyc", 32'(s_cyc_o), 32'h1);
    chk("hang_err", 32'(m0_err_o), 32'h0);
    chk("hang_gnt", 32'(gnt_o), 32'h1);
    idle_inputs();
    tick();
`endif

    // randomized traffic against the ownership model
    do_reset();
    owner = -1; last = 1; c[0] = 0; c[1] = 0; stall = 0;
    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (c[m]) begin
          if (owner == m && $urandom_range(3) == 0) c[m] = 0;
        end else if ($urandom_range(1) == 0) begin
          c[m] = 1;
        end
        adr[m] = $urandom;
      end
      stb_exp = (owner >= 0) && c[owner];
      ack = stb_exp && (($urandom_range(1) == 1) || stall >= 2);
      stall = (stb_exp && !ack) ? stall + 1 : 0;
      m0_cyc_i = c[0]; m0_stb_i = c[0]; m0_adr_i = adr[0];
      m1_cyc_i = c[1]; m1_stb_i = c[1]; m1_adr_i = adr[1];
      s_ack_i = ack; s_dat_i = $urandom;
      #1;
      chk("rnd_cyc", 32'(s_cyc_o), 32'(stb_exp));
      chk("rnd_ack0", 32'(m0_ack_o), 32'(ack && owner == 0));
      chk("rnd_ack1", 32'(m1_ack_o), 32'(ack && owner == 1));
      chk("rnd_adr", s_adr_o, adr[last]);
      chk("rnd_rdat", m1_dat_o, s_dat_i);
      @(posedge wb_clk_i);
      if (owner < 0) begin
        if (c[0] && c[1]) owner = (last == 1) ? 0 : 1;
        else if (c[0]) owner = 0;
        else if (c[1]) owner = 1;
      end else if (!c[owner]) begin
        owner = c[1 - owner] ? 1 - owner : -1;
      end
      if (owner >= 0) last = owner;
      #1;
      gnt_exp = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
      chk("rnd_gnt", 32'(gnt_o), 32'(gnt_exp));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
